// File: rtl/mips_pkg.sv
// Shared loader definitions: state encoding and default instruction memory size.
package mips_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams a program into instruction memory, verifies an XOR checksum byte,
// then holds the core in reset for RESET_HOLD cycles before releasing it.
module program_loader
    import mips_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_req,
    input  logic [8:0] load_len,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] instruction_mem [MEM_BYTES],
    output logic       core_reset,
    output logic       busy,
    output logic       load_ok,
    output logic       load_err
);

    localparam int unsigned LEN_W  = 9;
    localparam int unsigned ADDR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len;
    logic [7:0]        checksum;
    logic [HOLD_W-1:0] hold_cnt;

    logic rx_ready_nxt;
    logic core_reset_nxt;
    logic busy_nxt;
    logic load_ok_nxt;
    logic load_err_nxt;

    logic len_ok_c;
    logic accept_c;
    logic last_byte_c;
    logic hold_done_c;

    assign len_ok_c    = (load_len != '0) && (32'(load_len) <= MEM_BYTES);
    assign accept_c    = rx_valid && rx_ready;
    assign last_byte_c = (count == len - LEN_W'(1));
    assign hold_done_c = (hold_cnt == HOLD_W'(RESET_HOLD - 1));

    // State and output registers; outputs are decoded from the next state so
    // they always match the state they are presented alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rx_ready   <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rx_ready   <= rx_ready_nxt;
            core_reset <= core_reset_nxt;
            busy       <= busy_nxt;
            load_ok    <= load_ok_nxt;
            load_err   <= load_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN, ERROR: begin
                if (load_req) begin
                    state_nxt = len_ok_c ? LOAD : ERROR;
                end
            end
            LOAD: begin
                if (accept_c && last_byte_c) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (accept_c) begin
                    state_nxt = (rx_data == checksum) ? HOLD : ERROR;
                end
            end
            HOLD: begin
                if (hold_done_c) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready_nxt   = 1'b0;
        core_reset_nxt = 1'b1;
        busy_nxt       = 1'b0;
        load_ok_nxt    = 1'b0;
        load_err_nxt   = 1'b0;
        case (state_nxt)
            LOAD, CHECK: begin
                rx_ready_nxt = 1'b1;
                busy_nxt     = 1'b1;
            end
            HOLD: busy_nxt = 1'b1;
            RUN: begin
                core_reset_nxt = 1'b0;
                load_ok_nxt    = 1'b1;
            end
            ERROR: load_err_nxt = 1'b1;
            default: ;
        endcase
    end

    // Memory, byte counter, running checksum and hold timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                instruction_mem[i] <= '0;
            end
            count    <= '0;
            len      <= '0;
            checksum <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE, RUN, ERROR: begin
                    if (load_req && len_ok_c) begin
                        for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                            instruction_mem[i] <= '0;
                        end
                        count    <= '0;
                        checksum <= '0;
                        len      <= load_len;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        instruction_mem[ADDR_W'(count)] <= rx_data;
                        checksum <= checksum ^ rx_data;
                        count    <= count + LEN_W'(1);
                        hold_cnt <= '0;
                    end
                end
                HOLD: hold_cnt <= hold_cnt + HOLD_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader against a byte-array model.
module tb_program_loader;

    localparam int MEM = 256;
    localparam int HOLD_CYC = 4;

    // {rx_ready, core_reset, busy, load_ok, load_err} expected in each phase
    localparam logic [4:0] ST_IDLE  = 5'b01000;
    localparam logic [4:0] ST_LOAD  = 5'b11100;
    localparam logic [4:0] ST_HOLD  = 5'b01100;
    localparam logic [4:0] ST_RUN   = 5'b00010;
    localparam logic [4:0] ST_ERROR = 5'b01001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_req = 1'b0;
    logic [8:0] load_len = '0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] mem_out [MEM];
    logic       core_reset;
    logic       busy;
    logic       load_ok;
    logic       load_err;

    logic [7:0] exp_mem [MEM];
    logic [4:0] status;
    int compared = 0;
    int mismatched = 0;

    assign status = {rx_ready, core_reset, busy, load_ok, load_err};

    program_loader #(.MEM_BYTES(MEM), .RESET_HOLD(HOLD_CYC)) dut (
        .clk(clk),
        .reset(reset),
        .load_req(load_req),
        .load_len(load_len),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .instruction_mem(mem_out),
        .core_reset(core_reset),
        .busy(busy),
        .load_ok(load_ok),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff();
        for (int i = 0; i < MEM; i++) begin
            if (mem_out[i] !== exp_mem[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MEM; i++) exp_mem[i] = 8'h00;
    endtask

    task automatic start_load(input int len);
        load_req = 1'b1;
        load_len = 9'(len);
        tick();
        load_req = 1'b0;
        load_len = 9'($urandom);
    endtask

    // Offers one byte, optionally after random idle gaps, until it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit taken;
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                tick();
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        forever begin
            taken = rx_ready;
            tick();
            n++;
            if (taken) break;
            if (n >= 64) begin
                compared++;
                mismatched++;
                $display("FAIL handshake_timeout byte=%h waited=%0d cycles, required acceptance", b, n);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic feed(input int len, input bit gaps, output logic [7:0] ck);
        logic [7:0] b;
        ck = 8'h00;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            exp_mem[i] = b;
            ck ^= b;
            send_byte(b, gaps);
        end
    endtask

    // Waits for core_reset to fall; returns cycles waited (bounded).
    task automatic wait_release(output int n);
        n = 0;
        while (core_reset === 1'b1 && n < 32) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int idx;
        reset = 1'b1;
        tick();
        tick();
        model_clear();
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL reset_status got=%b required=%b", status, ST_IDLE);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL reset_mem addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
        reset = 1'b0;
        tick();
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL idle_status got=%b required=%b", status, ST_IDLE);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] prog [4];
        logic [7:0] ck;
        int n;
        int idx;
        prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
        start_load(4);
        model_clear();
        compared++;
        if (status !== ST_LOAD) begin
            mismatched++;
            $display("FAIL basic_enter_load got=%b required=%b", status, ST_LOAD);
        end
        ck = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_mem[i] = prog[i];
            ck ^= prog[i];
            send_byte(prog[i], 1'b0);
        end
        compared++;
        if (status !== ST_LOAD) begin
            mismatched++;
            $display("FAIL basic_check_phase got=%b required=%b", status, ST_LOAD);
        end
        send_byte(8'h89, 1'b0);
        compared++;
        if (status !== ST_HOLD || ck !== 8'h89) begin
            mismatched++;
            $display("FAIL basic_hold got=%b required=%b", status, ST_HOLD);
        end
        wait_release(n);
        compared++;
        if (n != HOLD_CYC) begin
            mismatched++;
            $display("FAIL basic_hold_len got=%0d required=%0d", n, HOLD_CYC);
        end
        compared++;
        if (status !== ST_RUN) begin
            mismatched++;
            $display("FAIL basic_run got=%b required=%b", status, ST_RUN);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL basic_mem addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
    endtask

    task automatic test_req_in_run();
        int idx;
        start_load(4);
        model_clear();
        compared++;
        if (status !== ST_LOAD) begin
            mismatched++;
            $display("FAIL run_reload_status got=%b required=%b", status, ST_LOAD);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL run_reload_zero addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
    endtask

    // Continues the load opened above: a stray request mid-load, then a bad checksum.
    task automatic test_bad_checksum();
        logic [7:0] prog [4];
        int idx;
        prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
        for (int i = 0; i < 4; i++) exp_mem[i] = prog[i];
        send_byte(prog[0], 1'b0);
        send_byte(prog[1], 1'b0);
        start_load(1);
        compared++;
        if (status !== ST_LOAD) begin
            mismatched++;
            $display("FAIL load_req_in_load got=%b required=%b", status, ST_LOAD);
        end
        send_byte(prog[2], 1'b0);
        send_byte(prog[3], 1'b0);
        send_byte(8'h00, 1'b0);
        tick();
        tick();
        compared++;
        if (status !== ST_ERROR) begin
            mismatched++;
            $display("FAIL bad_ck_status got=%b required=%b", status, ST_ERROR);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL bad_ck_mem addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
    endtask

    task automatic test_bad_len();
        int lens [2];
        int idx;
        lens[0] = 0;
        lens[1] = 257;
        for (int k = 0; k < 2; k++) begin
            start_load(lens[k]);
            compared++;
            if (status !== ST_ERROR) begin
                mismatched++;
                $display("FAIL bad_len_%0d_status got=%b required=%b", lens[k], status, ST_ERROR);
            end
            compared++;
            idx = first_diff();
            if (idx != -1) begin
                mismatched++;
                $display("FAIL bad_len_%0d_mem addr=%0d got=%h required=%h", lens[k], idx, mem_out[idx], exp_mem[idx]);
            end
        end
    endtask

    task automatic test_full_length();
        logic [7:0] ck;
        logic [7:0] b;
        int n;
        int idx;
        start_load(MEM);
        model_clear();
        ck = 8'h00;
        for (int i = 0; i < MEM; i++) begin
            b = 8'($urandom);
            exp_mem[i] = b;
            ck ^= b;
            send_byte(b, 1'b1);
            if (i == 100) begin
                start_load(3);
                compared++;
                if (status !== ST_LOAD) begin
                    mismatched++;
                    $display("FAIL full_req_ignored got=%b required=%b", status, ST_LOAD);
                end
            end
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL full_mem addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
        send_byte(ck, 1'b1);
        start_load(4);
        wait_release(n);
        compared++;
        if (n != HOLD_CYC - 1 || status !== ST_RUN) begin
            mismatched++;
            $display("FAIL full_hold_with_req got=%0d/%b required=%0d/%b", n, status, HOLD_CYC - 1, ST_RUN);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL full_mem_final addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] ck;
        int n;
        int idx;
        start_load(4);
        model_clear();
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        reset = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        tick();
        reset = 1'b0;
        rx_valid = 1'b0;
        tick();
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL mid_reset_status got=%b required=%b", status, ST_IDLE);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL mid_reset_mem addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
        start_load(4);
        feed(4, 1'b1, ck);
        send_byte(ck, 1'b0);
        wait_release(n);
        compared++;
        if (status !== ST_RUN || n != HOLD_CYC) begin
            mismatched++;
            $display("FAIL mid_reset_reload got=%b/%0d required=%b/%0d", status, n, ST_RUN, HOLD_CYC);
        end
        compared++;
        idx = first_diff();
        if (idx != -1) begin
            mismatched++;
            $display("FAIL mid_reset_reload_mem addr=%0d got=%h required=%h", idx, mem_out[idx], exp_mem[idx]);
        end
    endtask

    task automatic test_random_loads();
        logic [7:0] ck;
        logic [4:0] want;
        bit good;
        int len;
        int n;
        int idx;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MEM + 1, 511));
                start_load(len);
                want = ST_ERROR;
            end else begin
                len = int'($urandom_range(1, MEM));
                good = ($urandom_range(0, 2) != 0);
                start_load(len);
                model_clear();
                feed(len, 1'b1, ck);
                send_byte(good ? ck : ck ^ 8'($urandom_range(1, 255)), 1'b1);
                if (good) wait_release(n);
                else tick();
                want = good ? ST_RUN : ST_ERROR;
            end
            compared++;
            if (status !== want) begin
                mismatched++;
                $display("FAIL rand_%0d_len%0d_status got=%b required=%b", it, len, status, want);
            end
            compared++;
            idx = first_diff();
            if (idx != -1) begin
                mismatched++;
                $display("FAIL rand_%0d_mem addr=%0d got=%h required=%h", it, idx, mem_out[idx], exp_mem[idx]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_req_in_run();
        test_bad_checksum();
        test_bad_len();
        test_full_length();
        test_reset_mid_load();
        test_random_loads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256: instruction memory size in bytes.
REQ-002 SHALL have parameter RESET_HOLD, default 4: cycles core_reset stays high after a verified load.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port load_req, input, 1: one-cycle request to start a program load.
REQ-007 SHALL have port load_len, input, 9: program byte count, legal range 1..MEM_BYTES, sampled with load_req.
REQ-008 SHALL have port rx_data, input, 8: incoming program or checksum byte.
REQ-009 SHALL have port rx_valid, input, 1: rx_data is valid.
REQ-010 SHALL have port rx_ready, output, 1: loader accepts a byte this cycle.
REQ-011 SHALL have port instruction_mem, output, 8 x MEM_BYTES: byte array driving the core's instruction_mem input.
REQ-012 SHALL have port core_reset, output, 1: drives the core's reset.
REQ-013 SHALL have port busy, output, 1: high in LOAD, CHECK and HOLD.
REQ-014 SHALL have port load_ok, output, 1: last load verified and core released.
REQ-015 SHALL have port load_err, output, 1: last load failed.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, HOLD, RUN and ERROR.
REQ-017 SHALL complete a byte handshake only when rx_valid and rx_ready are both high on a rising edge.
REQ-018 In IDLE, RUN or ERROR, load_req with legal load_len SHALL, next cycle: zero all instruction_mem bytes, clear count and checksum, clear load_ok and load_err, assert core_reset, enter LOAD.
REQ-019 load_req with load_len of 0 or above MEM_BYTES SHALL enter ERROR with load_err=1 and leave memory unchanged.
REQ-020 load_req SHALL be ignored in LOAD, CHECK and HOLD.
REQ-021 In LOAD, rx_ready SHALL be 1, and each handshake SHALL write instruction_mem[count]=rx_data, XOR rx_data into the 8-bit checksum, and increment count.
REQ-022 A handshake at count==load_len-1 SHALL enter CHECK; there is no wrap-around, so address MEM_BYTES-1 is the last byte written.
REQ-023 In CHECK, rx_ready SHALL be 1 and the next handshake byte SHALL be compared with the checksum: equal enters HOLD, unequal enters ERROR.
REQ-024 HOLD SHALL last exactly RESET_HOLD cycles with core_reset=1, then enter RUN.
REQ-025 In RUN: core_reset=0 and load_ok=1.
REQ-026 In ERROR: core_reset=1 and load_err=1, with memory contents retained until the next load.
REQ-027 rx_ready SHALL be 0 in IDLE, HOLD, RUN and ERROR.
REQ-028 All outputs SHALL be registered; rx_ready and core_reset SHALL reflect the current state with no combinational path from inputs.
REQ-029 load_ok and load_err SHALL never be high simultaneously.

Reset
REQ-030 On reset: state IDLE, instruction_mem all 0, count=0, checksum=0, rx_ready=0, core_reset=1, busy=0, load_ok=0, load_err=0.
REQ-031 Reset mid-LOAD or mid-CHECK SHALL abort the load with no partial RUN, ending in the REQ-030 values.

Structure
REQ-032 Shared package mips_pkg SHALL hold the loader_state_t enum and the MEM_BYTES_DEFAULT constant.
REQ-033 SHALL be a single module with no sub-module; checksum and counters are inline.

Verification
REQ-034 load_req with len=4, bytes 8C 01 00 04, checksum 89 -> mem[0..3]=8C 01 00 04, rest 0; core_reset falls 4 cycles after entering HOLD; load_ok=1.
REQ-035 Same load with checksum 00 -> ERROR, load_err=1, core_reset stays 1, rx_ready=0.
REQ-036 load_len=0 and load_len=257 -> ERROR next cycle; memory unchanged.
REQ-037 len=256 with rx_valid toggling randomly -> all 256 bytes stored in order, mem[255] last, no extra writes.
REQ-038 reset after 2 of 4 bytes -> IDLE, memory all 0; a new load_req then succeeds normally.
REQ-039 load_req in RUN -> core_reset=1 next cycle, memory zeroed, LOAD entered; load_req in LOAD or HOLD -> no effect.
